// File: rtl/ula_4bit_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ula_4bit_mc                                                    |
// | Brief   : Multi-cycle 4-bit ALU, enable/ack responder. Define            |
// |           ULA_MULDIV_EN for iterative MUL/DIV/MOD (sel 8-10).            |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module ula_4bit_mc #(
   parameter int ITER_W = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [3:0] sel,
   output logic [3:0] result,
   output logic       ula_ack,
   output logic       busy,
   output logic       carry,
   output logic       zero,
   output logic       err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SHR = 4'd7;

   // The iteration counter must be able to reach 4.
   if (ITER_W < 3) begin : g_iter_w_check
      $error("ula_4bit_mc: ITER_W must be at least 3");
   end

   logic [1:0] state_q, state_d;
   logic [3:0] a_q, a_d, b_q, b_d, sel_q, sel_d;
   logic [3:0] result_q, result_d;
   logic       carry_q, carry_d, zero_q, zero_d, err_q, err_d;

   logic [3:0] alu_res;
   logic       alu_carry, alu_err;

   always_comb begin
      alu_res   = 4'd0;
      alu_carry = 1'b0;
      alu_err   = 1'b0;
      case (sel_q)
         OP_ADD: {alu_carry, alu_res} = {1'b0, a_q} + {1'b0, b_q};
         OP_SUB: begin
            alu_res   = a_q - b_q;
            alu_carry = (a_q < b_q);
         end
         OP_AND: alu_res = a_q & b_q;
         OP_OR:  alu_res = a_q | b_q;
         OP_XOR: alu_res = a_q ^ b_q;
         OP_NOT: alu_res = ~a_q;
         OP_SHL: begin
            alu_res   = {a_q[2:0], 1'b0};
            alu_carry = a_q[3];
         end
         OP_SHR: begin
            alu_res   = {1'b0, a_q[3:1]};
            alu_carry = a_q[0];
         end
         default: alu_err = 1'b1;
      endcase
   end

`ifdef ULA_MULDIV_EN
   localparam logic [1:0] ST_ITER = 2'd2;
   localparam logic [3:0] OP_MUL  = 4'd8;
   localparam logic [3:0] OP_DIV  = 4'd9;

   // acc holds the product for MUL and the partial remainder (low nibble) for DIV/MOD;
   // quo starts as the dividend and shifts quotient bits in from the right.
   logic [ITER_W-1:0] cnt_q, cnt_d;
   logic [7:0]        acc_q, acc_d, acc_nx;
   logic [3:0]        quo_q, quo_d, quo_nx;
   logic [4:0]        trial;
   logic              last_step;
   logic [3:0]        it_res;
   logic              it_carry, it_err;

   always_comb begin
      trial     = {acc_q[3:0], quo_q[3]};
      acc_nx    = acc_q;
      quo_nx    = quo_q;
      last_step = (cnt_q == ITER_W'(3));
      if (sel_q == OP_MUL) begin
         if (b_q[cnt_q[1:0]]) begin
            acc_nx = acc_q + ({4'd0, a_q} << cnt_q);
         end
      end else begin
         quo_nx = {quo_q[2:0], 1'b0};
         acc_nx = {4'd0, trial[3:0]};
         if (trial >= {1'b0, b_q}) begin
            acc_nx    = {4'd0, 4'(trial - {1'b0, b_q})};
            quo_nx[0] = 1'b1;
         end
      end
   end

   // A zero divisor needs no special path: every trial subtract succeeds,
   // giving quotient 4'hF and remainder a.
   always_comb begin
      it_res   = acc_nx[3:0];
      it_carry = 1'b0;
      it_err   = 1'b0;
      case (sel_q)
         OP_MUL: it_carry = |acc_nx[7:4];
         OP_DIV: begin
            it_res = quo_nx;
            it_err = (b_q == 4'd0);
         end
         default: it_err = (b_q == 4'd0);
      endcase
   end
`endif

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sel_d    = sel_q;
      result_d = result_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      err_d    = err_q;
`ifdef ULA_MULDIV_EN
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      quo_d    = quo_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               a_d     = a;
               b_d     = b;
               sel_d   = sel;
               state_d = ST_EXEC;
`ifdef ULA_MULDIV_EN
               if (sel == 4'd8 || sel == 4'd9 || sel == 4'd10) begin
                  state_d = ST_ITER;
                  cnt_d   = '0;
                  acc_d   = 8'd0;
                  quo_d   = a;
               end
`endif
            end
         end
         ST_EXEC: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else begin
               result_d = alu_res;
               carry_d  = alu_carry;
               err_d    = alu_err;
               zero_d   = (alu_res == 4'd0);
               state_d  = ST_DONE;
            end
         end
`ifdef ULA_MULDIV_EN
         ST_ITER: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + ITER_W'(1);
               acc_d = acc_nx;
               quo_d = quo_nx;
               if (last_step) begin
                  result_d = it_res;
                  carry_d  = it_carry;
                  err_d    = it_err;
                  zero_d   = (it_res == 4'd0);
                  state_d  = ST_DONE;
               end
            end
         end
`endif
         ST_DONE: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         a_q      <= 4'd0;
         b_q      <= 4'd0;
         sel_q    <= 4'd0;
         result_q <= 4'd0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
`ifdef ULA_MULDIV_EN
         cnt_q    <= '0;
         acc_q    <= 8'd0;
         quo_q    <= 4'd0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sel_q    <= sel_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         err_q    <= err_d;
`ifdef ULA_MULDIV_EN
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         quo_q    <= quo_d;
`endif
      end
   end

   assign result  = result_q;
   assign carry   = carry_q;
   assign zero    = zero_q;
   assign err     = err_q;
   assign ula_ack = (state_q == ST_DONE);
`ifdef ULA_MULDIV_EN
   assign busy    = (state_q == ST_EXEC) || (state_q == ST_ITER);
`else
   assign busy    = (state_q == ST_EXEC);
`endif

endmodule
`default_nettype wire

// File: tb/tb_ula_4bit_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_ula_4bit_mc                                                 |
// | Brief   : Directed self-checking bench for ula_4bit_mc (both builds of   |
// |           ULA_MULDIV_EN).                                                |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ula_4bit_mc;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic [3:0] a = 4'd0;
   logic [3:0] b = 4'd0;
   logic [3:0] sel = 4'd0;
   logic [3:0] result;
   logic       ula_ack, busy, carry, zero, err;

   int errors = 0;
   int checks = 0;

   ula_4bit_mc #(.ITER_W(3)) dut (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .a       (a),
      .b       (b),
      .sel     (sel),
      .result  (result),
      .ula_ack (ula_ack),
      .busy    (busy),
      .carry   (carry),
      .zero    (zero),
      .err     (err)
   );

   always #5 clk = ~clk;

   // Single-cycle op vectors: a, b, sel -> result, {carry, zero, err}
   logic [3:0] sv_a   [0:10] = '{4'h2, 4'h5, 4'hC, 4'hC, 4'hF, 4'h5, 4'h9, 4'h9, 4'h3, 4'h7, 4'h1};
   logic [3:0] sv_b   [0:10] = '{4'h3, 4'h5, 4'hA, 4'h3, 4'hF, 4'h0, 4'h0, 4'h0, 4'h3, 4'h9, 4'h1};
   logic [3:0] sv_sel [0:10] = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd12, 4'd0, 4'd15};
   logic [3:0] sv_res [0:10] = '{4'hF, 4'h0, 4'h8, 4'hF, 4'h0, 4'hA, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0};
   logic [2:0] sv_flg [0:10] = '{3'b100, 3'b010, 3'b000, 3'b000, 3'b010, 3'b000, 3'b100, 3'b100,
                                 3'b011, 3'b110, 3'b011};

`ifdef ULA_MULDIV_EN
   localparam int NMD = 8;
   logic [3:0] md_a   [0:NMD-1] = '{4'd7, 4'd13, 4'd13, 4'd6, 4'd6, 4'd3, 4'd0, 4'd4};
   logic [3:0] md_b   [0:NMD-1] = '{4'd3, 4'd4, 4'd4, 4'd0, 4'd0, 4'd5, 4'd9, 4'd4};
   logic [3:0] md_sel [0:NMD-1] = '{4'd8, 4'd9, 4'd10, 4'd9, 4'd10, 4'd8, 4'd8, 4'd8};
   logic [3:0] md_res [0:NMD-1] = '{4'h5, 4'h3, 4'h1, 4'hF, 4'h6, 4'hF, 4'h0, 4'h0};
   logic [2:0] md_flg [0:NMD-1] = '{3'b100, 3'b000, 3'b000, 3'b001, 3'b001, 3'b000, 3'b010, 3'b110};
   localparam int MD_LAT  = 5;
   localparam int MD_BUSY = 4;
   localparam int ABORT_EDGES = 2;
   localparam int RST_EDGES   = 3;
`else
   localparam int NMD = 3;
   logic [3:0] md_a   [0:NMD-1] = '{4'd7, 4'd13, 4'd13};
   logic [3:0] md_b   [0:NMD-1] = '{4'd3, 4'd4, 4'd4};
   logic [3:0] md_sel [0:NMD-1] = '{4'd8, 4'd9, 4'd10};
   logic [3:0] md_res [0:NMD-1] = '{4'h0, 4'h0, 4'h0};
   logic [2:0] md_flg [0:NMD-1] = '{3'b011, 3'b011, 3'b011};
   localparam int MD_LAT  = 2;
   localparam int MD_BUSY = 1;
   localparam int ABORT_EDGES = 1;
   localparam int RST_EDGES   = 1;
`endif

   // Raise a request and wait (bounded) for ack; operands are scrambled
   // after the accept edge. Called #1 after a rising edge.
   task automatic do_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic [3:0] ts,
                        output int lat, output int bcnt);
      a = ta; b = tb_v; sel = ts; enable = 1'b1;
      lat = 0; bcnt = 0;
      while (lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) begin
            a = ~ta; b = ~tb_v; sel = ~ts;
         end
         if (busy) bcnt++;
         if (ula_ack) break;
      end
   endtask

   task automatic release_op();
      enable = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({result, ula_ack, busy, carry, zero, err} !== 9'h000) begin
         errors++;
         $display("FAIL reset_async: got %h expected 000", {result, ula_ack, busy, carry, zero, err});
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({result, ula_ack, busy, carry, zero, err} !== 9'h000) begin
         errors++;
         $display("FAIL reset_release: got %h expected 000", {result, ula_ack, busy, carry, zero, err});
      end
   endtask

   task automatic test_add();
      int lat, bc;
      do_op(4'd9, 4'd8, 4'd0, lat, bc);
      checks++;
      if (lat !== 2) begin
         errors++; $display("FAIL add_latency: got %0d expected 2", lat);
      end
      checks++;
      if (bc !== 1) begin
         errors++; $display("FAIL add_busy_cycles: got %0d expected 1", bc);
      end
      checks++;
      if ({result, carry, zero, err} !== {4'h1, 3'b100}) begin
         errors++; $display("FAIL add_value: got %b expected %b", {result, carry, zero, err}, {4'h1, 3'b100});
      end
      @(posedge clk); #1;
      checks++;
      if ({ula_ack, busy} !== 2'b10) begin
         errors++; $display("FAIL add_ack_hold: got ack/busy %b expected 10", {ula_ack, busy});
      end
      release_op();
      checks++;
      if ({ula_ack, result} !== {1'b0, 4'h1}) begin
         errors++; $display("FAIL add_ack_drop: got ack/result %b expected 0_0001", {ula_ack, result});
      end
   endtask

   task automatic test_single_ops();
      int lat, bc;
      for (int i = 0; i < 11; i++) begin
         do_op(sv_a[i], sv_b[i], sv_sel[i], lat, bc);
         checks++;
         if ({result, carry, zero, err} !== {sv_res[i], sv_flg[i]} || lat !== 2) begin
            errors++;
            $display("FAIL single_op%0d sel=%0d: got res/flags %b lat %0d expected %b lat 2",
                     i, sv_sel[i], {result, carry, zero, err}, lat, {sv_res[i], sv_flg[i]});
         end
         release_op();
      end
   endtask

   task automatic test_muldiv();
      int lat, bc;
      for (int i = 0; i < NMD; i++) begin
         do_op(md_a[i], md_b[i], md_sel[i], lat, bc);
         checks++;
         if ({result, carry, zero, err} !== {md_res[i], md_flg[i]}) begin
            errors++;
            $display("FAIL muldiv%0d sel=%0d a=%0d b=%0d: got res/flags %b expected %b",
                     i, md_sel[i], md_a[i], md_b[i], {result, carry, zero, err}, {md_res[i], md_flg[i]});
         end
         checks++;
         if (lat !== MD_LAT || bc !== MD_BUSY) begin
            errors++;
            $display("FAIL muldiv%0d_timing: got lat %0d busy %0d expected lat %0d busy %0d",
                     i, lat, bc, MD_LAT, MD_BUSY);
         end
         release_op();
      end
   endtask

   task automatic test_abort();
      int lat, bc;
      int acks;
      do_op(4'd3, 4'd4, 4'd0, lat, bc);
      release_op();
      a = 4'd7; b = 4'd3; sel = 4'd8; enable = 1'b1;
      repeat (ABORT_EDGES) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL abort_busy_before: got %b expected 1", busy);
      end
      enable = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({busy, ula_ack, result, carry, zero, err} !== {2'b00, 4'h7, 3'b000}) begin
         errors++;
         $display("FAIL abort_state: got busy/ack/res/flags %b expected %b",
                  {busy, ula_ack, result, carry, zero, err}, {2'b00, 4'h7, 3'b000});
      end
      acks = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (ula_ack || busy) acks++;
      end
      checks++;
      if (acks !== 0) begin
         errors++; $display("FAIL abort_no_ack: got %0d active cycles expected 0", acks);
      end
   endtask

   task automatic test_reset_mid_op();
      int lat, bc;
      do_op(4'd9, 4'd8, 4'd0, lat, bc);
      release_op();
      a = 4'd13; b = 4'd4; sel = 4'd9; enable = 1'b1;
      repeat (RST_EDGES) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL rstmid_busy_before: got %b expected 1", busy);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({result, ula_ack, busy, carry, zero, err} !== 9'h000) begin
         errors++;
         $display("FAIL rstmid_outputs: got %h expected 000", {result, ula_ack, busy, carry, zero, err});
      end
      enable = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      do_op(4'd2, 4'd3, 4'd1, lat, bc);
      checks++;
      if ({result, carry, zero, err} !== {4'hF, 3'b100} || lat !== 2) begin
         errors++;
         $display("FAIL rstmid_sub_after: got res/flags %b lat %0d expected %b lat 2",
                  {result, carry, zero, err}, lat, {4'hF, 3'b100});
      end
      release_op();
   endtask

   task automatic test_back_to_back();
      int lat, bc;
      do_op(4'd1, 4'd1, 4'd0, lat, bc);
      checks++;
      if (result !== 4'h2 || lat !== 2) begin
         errors++; $display("FAIL b2b_first: got res %h lat %0d expected 2 lat 2", result, lat);
      end
      release_op();
      do_op(4'd6, 4'd3, 4'd4, lat, bc);
      checks++;
      if (result !== 4'h5 || lat !== 2) begin
         errors++; $display("FAIL b2b_second: got res %h lat %0d expected 5 lat 2", result, lat);
      end
      release_op();
   endtask

   initial begin
      test_reset();
      test_add();
      test_single_ops();
      test_muldiv();
      test_abort();
      test_reset_mid_op();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
